// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
package rf_wb_arbiter_pkg;

   localparam int unsigned REG_W    = 5;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned NUM_REGS = 32;

   localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant scanning upward from a pointer that
// moves just past the winner whenever the caller reports an accepted grant.
module rf_wb_arbiter_rr_arbiter #(
   parameter int unsigned N     = 3,
   parameter int unsigned IDX_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [N-1:0]     req_i,
   input  logic             advance_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W:0]   pos;
   logic             found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      pos   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = {1'b0, ptr_q} + (IDX_W + 1)'(k);
         if (pos >= (IDX_W + 1)'(N)) begin
            pos = pos - (IDX_W + 1)'(N);
         end
         if (!found && req_i[pos[IDX_W-1:0]]) begin
            found                    = 1'b1;
            gnt_o[pos[IDX_W-1:0]]    = 1'b1;
            idx_o                    = pos[IDX_W-1:0];
         end
      end
      // Nothing is granted while reset is held.
      if (rst_i) begin
         gnt_o = '0;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance_i) begin
         ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among NREQ requesters and tracks
// destination registers with writes in flight for RAW hazard detection.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int unsigned NREQ  = 3,
   parameter int unsigned PTR_W = 2
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NREQ-1:0]          req_valid_i,
   input  logic [REG_W*NREQ-1:0]    req_rw_i,
   input  logic [DATA_W*NREQ-1:0]   req_data_i,
   output logic [NREQ-1:0]          req_ready_o,
   input  logic                     rsv_valid_i,
   input  logic [REG_W-1:0]         rsv_reg_i,
   output logic [REG_W-1:0]         rw_o,
   output logic [DATA_W-1:0]        busw_o,
   output logic                     regwr_o,
   output logic [NUM_REGS-1:0]      busy_mask_o,
   output logic                     idle_o
);

   logic [PTR_W-1:0]    gnt_idx;
   logic                xfer;
   logic [REG_W-1:0]    sel_rw;
   logic [DATA_W-1:0]   sel_data;

   logic [REG_W-1:0]    rw_q, rw_d;
   logic [DATA_W-1:0]   busw_q, busw_d;
   logic                regwr_q, regwr_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;

   rf_wb_arbiter_rr_arbiter #(
      .N     (NREQ),
      .IDX_W (PTR_W)
   ) u_rr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (req_valid_i),
      .advance_i (xfer),
      .gnt_o     (req_ready_o),
      .idx_o     (gnt_idx)
   );

   // Grants only ever go to valid requesters, so any grant is a transfer.
   assign xfer     = |req_ready_o;
   assign sel_rw   = req_rw_i[int'(gnt_idx) * REG_W +: REG_W];
   assign sel_data = req_data_i[int'(gnt_idx) * DATA_W +: DATA_W];

   always_comb begin
      rw_d    = rw_q;
      busw_d  = busw_q;
      regwr_d = 1'b0;
      if (xfer) begin
         rw_d    = sel_rw;
         busw_d  = sel_data;
         regwr_d = (sel_rw != REG_ZERO);
      end
   end

   // Clear first so a same-cycle reservation of the retiring register wins.
   always_comb begin
      busy_d = busy_q;
      if (regwr_q) begin
         busy_d[rw_q] = 1'b0;
      end
      if (rsv_valid_i && (rsv_reg_i != REG_ZERO)) begin
         busy_d[rsv_reg_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rw_q    <= '0;
         busw_q  <= '0;
         regwr_q <= 1'b0;
         busy_q  <= '0;
      end else begin
         rw_q    <= rw_d;
         busw_q  <= busw_d;
         regwr_q <= regwr_d;
         busy_q  <= busy_d;
      end
   end

   assign rw_o        = rw_q;
   assign busw_o      = busw_q;
   assign regwr_o     = regwr_q;
   assign busy_mask_o = busy_q;
   assign idle_o      = ~|req_valid_i & ~regwr_q & ~|busy_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed vector bench for rf_wb_arbiter: one vector per clock cycle.
module tb_rf_wb_arbiter;

   logic         clk;
   logic         rst;
   logic [2:0]   req_valid;
   logic [14:0]  req_rw;
   logic [95:0]  req_data;
   logic [2:0]   req_ready;
   logic         rsv_valid;
   logic [4:0]   rsv_reg;
   logic [4:0]   rw;
   logic [31:0]  busw;
   logic         regwr;
   logic [31:0]  busy_mask;
   logic         idle;

   int n_cmp = 0;
   int n_err = 0;

   rf_wb_arbiter #(
      .NREQ  (3),
      .PTR_W (2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_rw_i    (req_rw),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .rsv_valid_i (rsv_valid),
      .rsv_reg_i   (rsv_reg),
      .rw_o        (rw),
      .busw_o      (busw),
      .regwr_o     (regwr),
      .busy_mask_o (busy_mask),
      .idle_o      (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [2:0]  vld;
      logic [4:0]  rw0, rw1, rw2;
      logic [31:0] d0, d1, d2;
      logic        rsv;
      logic [4:0]  rreg;
      logic [2:0]  exp_rdy;
      logic        exp_idle;
      logic        exp_regwr;
      logic [4:0]  exp_rw;
      logic [31:0] exp_busw;
      logic [31:0] exp_busy;
   } vec_t;

   vec_t vecs[$];

   localparam logic [31:0] A0 = 32'h0000_00A0;
   localparam logic [31:0] A1 = 32'h0000_00A1;
   localparam logic [31:0] A2 = 32'h0000_00A2;
   localparam logic [31:0] B9 = 32'h0000_0200;
   localparam logic [31:0] B5 = 32'h0000_0020;
   localparam logic [31:0] BC = 32'h0000_1000;

   task automatic check(input string name, input int idx, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s vec=%0d got=%h expected=%h", name, idx, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst       = v.rst;
      req_valid = v.vld;
      req_rw    = {v.rw2, v.rw1, v.rw0};
      req_data  = {v.d2, v.d1, v.d0};
      rsv_valid = v.rsv;
      rsv_reg   = v.rreg;
   endtask

   initial begin
      vec_t v;
      logic [2:0] hand_exp[4];
      rst = 1'b1; req_valid = '0; req_rw = '0; req_data = '0;
      rsv_valid = 1'b0; rsv_reg = '0;

      // rst vld rw0 rw1 rw2 d0 d1 d2 rsv rreg | rdy idle regwr rw busw busy
      vecs.push_back('{1'b1, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0});
      // single request
      vecs.push_back('{1'b0, 3'b001, 5'd8, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 5'd0,  3'b001, 1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b0, 1'b0, 5'd8, 32'hDEADBEEF, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b1, 1'b0, 5'd8, 32'hDEADBEEF, 32'h0});
      vecs.push_back('{1'b1, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b1, 1'b0, 5'd0, 32'h0, 32'h0});
      // round-robin, all valid
      vecs.push_back('{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b001, 1'b0, 1'b1, 5'd1, A0, 32'h0});
      vecs.push_back('{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b010, 1'b0, 1'b1, 5'd2, A1, 32'h0});
      vecs.push_back('{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b100, 1'b0, 1'b1, 5'd3, A2, 32'h0});
      vecs.push_back('{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b001, 1'b0, 1'b1, 5'd1, A0, 32'h0});
      vecs.push_back('{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b010, 1'b0, 1'b1, 5'd2, A1, 32'h0});
      vecs.push_back('{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b100, 1'b0, 1'b1, 5'd3, A2, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b0, 1'b0, 5'd3, A2, 32'h0});
      // $zero sink from req 1, then req 2 wins first
      vecs.push_back('{1'b0, 3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'h1234, 32'h0, 1'b0, 5'd0,  3'b010, 1'b0, 1'b0, 5'd0, 32'h1234, 32'h0});
      vecs.push_back('{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b100, 1'b0, 1'b1, 5'd3, A2, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b0, 1'b0, 5'd3, A2, 32'h0});
      // scoreboard: reserve 9, write back 9
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9,  3'b000, 1'b1, 1'b0, 5'd3, A2, B9});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b0, 1'b0, 5'd3, A2, B9});
      vecs.push_back('{1'b0, 3'b001, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0, 1'b0, 5'd0,  3'b001, 1'b0, 1'b1, 5'd9, 32'h99, B9});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b0, 1'b0, 5'd9, 32'h99, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b1, 1'b0, 5'd9, 32'h99, 32'h0});
      // write to non-busy reg 5, then reserve 5 while it retires
      vecs.push_back('{1'b0, 3'b010, 5'd0, 5'd5, 5'd0, 32'h0, 32'h55, 32'h0, 1'b0, 5'd0,  3'b010, 1'b0, 1'b1, 5'd5, 32'h55, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd5,  3'b000, 1'b0, 1'b0, 5'd5, 32'h55, B5});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd0,  3'b000, 1'b0, 1'b0, 5'd5, 32'h55, B5});
      vecs.push_back('{1'b0, 3'b100, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 32'h77, 1'b0, 5'd0,  3'b100, 1'b0, 1'b1, 5'd5, 32'h77, B5});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b0, 1'b0, 5'd5, 32'h77, 32'h0});
      // reset mid-stream with a staged write and a busy register
      vecs.push_back('{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b1, 5'd12, 3'b001, 1'b0, 1'b1, 5'd1, A0, BC});
      vecs.push_back('{1'b1, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0});
      vecs.push_back('{1'b0, 3'b111, 5'd1, 5'd2, 5'd3, A0, A1, A2, 1'b0, 5'd0,  3'b001, 1'b0, 1'b1, 5'd1, A0, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b0, 1'b0, 5'd1, A0, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0,  3'b000, 1'b1, 1'b0, 5'd1, A0, 32'h0});

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk);
         drive(v);
         #1;
         check("req_ready", i, 32'(req_ready), 32'(v.exp_rdy));
         check("idle", i, 32'(idle), 32'(v.exp_idle));
         @(posedge clk);
         #1;
         check("regwr", i, 32'(regwr), 32'(v.exp_regwr));
         check("rw", i, 32'(rw), 32'(v.exp_rw));
         check("busw", i, busw, v.exp_busw);
         check("busy_mask", i, busy_mask, v.exp_busy);
      end

      // Requesters 0 and 2 held valid: pointer sits at 1, so grants alternate 2,0,2,0.
      hand_exp[0] = 3'b100; hand_exp[1] = 3'b001; hand_exp[2] = 3'b100; hand_exp[3] = 3'b001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rst = 1'b0; rsv_valid = 1'b0; rsv_reg = '0;
         req_valid = 3'b101;
         req_rw    = {5'd7, 5'd0, 5'd6};
         req_data  = {32'h2222, 32'h0, 32'h1111};
         #1;
         check("alt_ready", i, 32'(req_ready), 32'(hand_exp[i]));
         @(posedge clk);
         #1;
         check("alt_rw", i, 32'(rw), (hand_exp[i] == 3'b100) ? 32'd7 : 32'd6);
         check("alt_regwr", i, 32'(regwr), 32'd1);
      end
      @(negedge clk);
      req_valid = '0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
